// File: rtl/santim_wdt.sv
// Sanity-pulse generator with an optional watchdog: a manual request or a missed
// kick produces a fixed-length pulse, and watchdog expiries are latched in a sticky flag.
module santim_wdt #(
   parameter int PRESC     = 1,
   parameter int PULSE_LEN = 10,
   parameter int CNT_W     = 8
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             ena_i,
   input  logic             gen_i,
   input  logic             mode_i,
   input  logic             kick_i,
   input  logic [CNT_W-1:0] tout_i,
   input  logic             clr_i,
   output logic             out_o,
   output logic             busy_o,
   output logic             expired_o
);

   localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam int LW = $clog2(PULSE_LEN + 1);

   typedef enum logic [1:0] {IDLE, ARMED, PULSE, HOLD} state_t;

   state_t           r_state;
   logic [PW-1:0]    r_presc;
   logic [LW-1:0]    r_pcnt;
   logic [CNT_W-1:0] r_tcnt;

   logic             w_tick;
   logic             w_pulseDone;
   logic [CNT_W-1:0] w_tload;

   assign w_tick      = (r_presc == PW'(PRESC - 1));
   assign w_pulseDone = w_tick && (r_pcnt == LW'(PULSE_LEN - 1));
   assign w_tload     = (tout_i == '0) ? CNT_W'(1) : tout_i;

   // Prescaler restarts on every pulse entry and timeout reload, so pulse length and
   // timeout are exact multiples of PRESC measured from that edge.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         r_state   <= IDLE;
         r_presc   <= '0;
         r_pcnt    <= '0;
         r_tcnt    <= '0;
         out_o     <= 1'b0;
         busy_o    <= 1'b0;
         expired_o <= 1'b0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (clr_i) expired_o <= 1'b0;

         if (!ena_i) begin
            r_state <= IDLE;
            r_presc <= '0;
            r_pcnt  <= '0;
            r_tcnt  <= '0;
            out_o   <= 1'b0;
            busy_o  <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (gen_i) begin
                     r_state <= PULSE;
                     r_presc <= '0;
                     r_pcnt  <= '0;
                     out_o   <= 1'b1;
                     busy_o  <= 1'b1;
                  end else if (mode_i) begin
                     r_state <= ARMED;
                     r_tcnt  <= w_tload;
                     r_presc <= '0;
                  end
               end

               ARMED: begin
                  if (gen_i) begin
                     r_state <= PULSE;
                     r_presc <= '0;
                     r_pcnt  <= '0;
                     out_o   <= 1'b1;
                     busy_o  <= 1'b1;
                  end else if (!mode_i) begin
                     r_state <= IDLE;
                     r_tcnt  <= '0;
                  end else if (kick_i) begin
                     r_tcnt  <= w_tload;
                     r_presc <= '0;
                  end else if (w_tick) begin
                     if (r_tcnt <= CNT_W'(1)) begin
                        r_state   <= PULSE;
                        r_tcnt    <= '0;
                        r_presc   <= '0;
                        r_pcnt    <= '0;
                        out_o     <= 1'b1;
                        busy_o    <= 1'b1;
                        expired_o <= 1'b1;
                     end else begin
                        r_tcnt <= r_tcnt - 1'b1;
                     end
                  end
               end

               PULSE: begin
                  if (w_pulseDone) begin
                     out_o  <= 1'b0;
                     r_pcnt <= '0;
                     if (gen_i) begin
                        r_state <= HOLD;
                     end else if (mode_i) begin
                        r_state <= ARMED;
                        r_tcnt  <= w_tload;
                        r_presc <= '0;
                        busy_o  <= 1'b0;
                     end else begin
                        r_state <= IDLE;
                        busy_o  <= 1'b0;
                     end
                  end else if (w_tick) begin
                     r_pcnt <= r_pcnt + 1'b1;
                  end
               end

               HOLD: begin
                  if (!gen_i) begin
                     busy_o <= 1'b0;
                     if (mode_i) begin
                        r_state <= ARMED;
                        r_tcnt  <= w_tload;
                        r_presc <= '0;
                     end else begin
                        r_state <= IDLE;
                     end
                  end
               end

               default: begin
                  r_state <= IDLE;
                  out_o   <= 1'b0;
                  busy_o  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_santim_wdt.sv
// Self-checking bench for santim_wdt: per-cycle vector table fed through a scoreboard,
// plus a hand-written asynchronous reset sequence.
module tb_santim_wdt;

   logic       clock_i = 1'b0;
   logic       reset_i;
   logic       ena_i;
   logic       gen_i;
   logic       mode_i;
   logic       kick_i;
   logic [7:0] tout_i;
   logic       clr_i;
   logic       out_o;
   logic       busy_o;
   logic       expired_o;

   typedef struct {
      string      tag;
      logic       ena;
      logic       gen;
      logic       mode;
      logic       kick;
      logic       clr;
      logic [7:0] tout;
      logic       eOut;
      logic       eBusy;
      logic       eExp;
   } vec_t;

   typedef struct {
      string tag;
      int    idx;
      logic  eOut;
      logic  eBusy;
      logic  eExp;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   testsRun    = 0;
   int   testsFailed = 0;

   santim_wdt #(.PRESC(1), .PULSE_LEN(10), .CNT_W(8)) dut (
      .clock_i  (clock_i),
      .reset_i  (reset_i),
      .ena_i    (ena_i),
      .gen_i    (gen_i),
      .mode_i   (mode_i),
      .kick_i   (kick_i),
      .tout_i   (tout_i),
      .clr_i    (clr_i),
      .out_o    (out_o),
      .busy_o   (busy_o),
      .expired_o(expired_o)
   );

   always #5 clock_i = ~clock_i;

   // Hard stop in case the run ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL global timeout: simulation did not finish, required finish before 2000000");
      $fatal(1);
   end

   task automatic compareBit(input string what, input logic act, input logic req);
      testsRun++;
      if (act !== req) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %b, expected %b", what, act, req);
      end
   endtask

   task automatic addVec(input string tag, input logic ena, input logic gen, input logic mode,
                         input logic kick, input logic clr, input logic [7:0] tout,
                         input logic eOut, input logic eBusy, input logic eExp);
      vec_t v;
      v.tag = tag; v.ena = ena; v.gen = gen; v.mode = mode; v.kick = kick; v.clr = clr;
      v.tout = tout; v.eOut = eOut; v.eBusy = eBusy; v.eExp = eExp;
      vecs.push_back(v);
   endtask

   // Return to IDLE with the sticky flag cleared between scenarios.
   task automatic addSeparator(input string tag);
      addVec(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL scoreboard: got empty queue, expected a pending entry");
      end else begin
         e = sb.pop_front();
         compareBit($sformatf("%s[%0d] out_o", e.tag, e.idx), out_o, e.eOut);
         compareBit($sformatf("%s[%0d] busy_o", e.tag, e.idx), busy_o, e.eBusy);
         compareBit($sformatf("%s[%0d] expired_o", e.tag, e.idx), expired_o, e.eExp);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      exp_t e;
      ena_i  = v.ena;
      gen_i  = v.gen;
      mode_i = v.mode;
      kick_i = v.kick;
      clr_i  = v.clr;
      tout_i = v.tout;
      e.tag = v.tag; e.idx = idx; e.eOut = v.eOut; e.eBusy = v.eBusy; e.eExp = v.eExp;
      sb.push_back(e);
      @(posedge clock_i);
      #1;
      checkOutput();
   endtask

   initial begin
      vec_t v;

      // Manual pulse: gen held 30 cycles, pulse 10 cycles, HOLD until gen falls.
      for (int i = 1; i <= 32; i++)
         addVec("manual", 1'b1, (i <= 30), 1'b0, 1'b0, 1'b0, 8'd0,
                (i <= 10), (i <= 30), 1'b0);
      addSeparator("sepA");

      // Watchdog timeout 5, no kick: expiry, re-arm, second expiry.
      for (int i = 1; i <= 30; i++)
         addVec("expire", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5,
                ((i >= 6 && i <= 15) || (i >= 21 && i <= 30)),
                ((i >= 6 && i <= 15) || (i >= 21 && i <= 30)),
                (i >= 6));
      addSeparator("sepB");

      // Watchdog serviced every 4 cycles never expires.
      for (int i = 1; i <= 100; i++)
         addVec("kicked", 1'b1, 1'b0, 1'b1, ((i % 4) == 0), 1'b0, 8'd5, 1'b0, 1'b0, 1'b0);
      addSeparator("sepC");

      // Enable dropped on the 4th pulse cycle: immediate IDLE, no HOLD.
      for (int i = 1; i <= 6; i++)
         addVec("enadrop", (i != 5), (i <= 5), 1'b0, 1'b0, 1'b0, 8'd0,
                (i <= 4), (i <= 4), 1'b0);
      addSeparator("sepD");

      // clr on the expiry edge loses to set; clr one cycle later clears.
      for (int i = 1; i <= 6; i++)
         addVec("clrrace", 1'b1, 1'b0, 1'b1, 1'b0, (i == 4 || i == 5), 8'd3,
                (i >= 4), (i >= 4), (i == 4));
      addSeparator("sepE");

      // gen in ARMED beats a simultaneous kick and does not flag expiry.
      addVec("genprio", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0);
      addVec("genprio", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd5, 1'b1, 1'b1, 1'b0);
      addSeparator("sepF");

      reset_i = 1'b1;
      ena_i = 1'b0; gen_i = 1'b0; mode_i = 1'b0; kick_i = 1'b0; clr_i = 1'b0; tout_i = 8'd0;
      repeat (2) @(posedge clock_i);
      #1;
      compareBit("reset out_o", out_o, 1'b0);
      compareBit("reset busy_o", busy_o, 1'b0);
      compareBit("reset expired_o", expired_o, 1'b0);
      @(negedge clock_i);
      reset_i = 1'b0;

      for (int i = 0; i < vecs.size(); i++)
         applyStimulus(vecs[i], i);

      // Asynchronous reset in the middle of a watchdog pulse, then tout=0 expiry.
      v.tag = "rstpre"; v.ena = 1'b1; v.gen = 1'b0; v.mode = 1'b1; v.kick = 1'b0;
      v.clr = 1'b0; v.tout = 8'd0; v.eOut = 1'b0; v.eBusy = 1'b0; v.eExp = 1'b0;
      applyStimulus(v, 0);
      v.eOut = 1'b1; v.eBusy = 1'b1; v.eExp = 1'b1;
      applyStimulus(v, 1);
      applyStimulus(v, 2);
      #2;
      reset_i = 1'b1;
      #1;
      compareBit("asyncrst out_o", out_o, 1'b0);
      compareBit("asyncrst busy_o", busy_o, 1'b0);
      compareBit("asyncrst expired_o", expired_o, 1'b0);
      @(negedge clock_i);
      reset_i = 1'b0;
      v.tag = "tout0"; v.eOut = 1'b0; v.eBusy = 1'b0; v.eExp = 1'b0;
      applyStimulus(v, 0);
      v.eOut = 1'b1; v.eBusy = 1'b1; v.eExp = 1'b1;
      applyStimulus(v, 1);

      if (sb.size() != 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/santim_wdt.md
SANTIM_WDT -- requirements
Module: santim_wdt

Interface
REQ-001 Parameter PRESC, default 1: clock_i cycles per tick, >=1.
REQ-002 Parameter PULSE_LEN, default 10: out_o pulse length in ticks, >=1.
REQ-003 Parameter CNT_W, default 8: watchdog timeout counter width.
REQ-004 clock_i  in  1  sole clock (2.5 MHz system use).
REQ-005 reset_i  in  1  asynchronous, active-high reset.
REQ-006 ena_i  in  1  enable; low forces IDLE.
REQ-007 gen_i  in  1  manual pulse request, level-sensitive.
REQ-008 mode_i  in  1  0 = manual only; 1 = watchdog armed.
REQ-009 kick_i  in  1  watchdog service, reloads timeout.
REQ-010 tout_i  in  CNT_W  timeout in ticks; 0 treated as 1.
REQ-011 clr_i  in  1  clears expired_o.
REQ-012 out_o  out  1  sanity pulse, active 1, registered.
REQ-013 busy_o  out  1  high in PULSE or HOLD.
REQ-014 expired_o  out  1  sticky watchdog-expiry flag.

Function
REQ-015 The prescaler SHALL count 0..PRESC-1, tick on PRESC-1, and clear when ena_i=0, on PULSE entry and on every timeout reload.
REQ-016 The state machine SHALL have states IDLE, ARMED, PULSE and HOLD.
REQ-017 ena_i=0 SHALL force IDLE on the next edge from any state, with out_o=0 and counters cleared.
REQ-018 IDLE with ena_i&gen_i SHALL go to PULSE; IDLE with ena_i&mode_i&!gen_i SHALL go to ARMED and load tout_i.
REQ-019 ARMED SHALL reload tout_i on kick_i, and decrement the timeout counter on each tick when kick_i is low.
REQ-020 ARMED SHALL go to PULSE and set expired_o on a tick with counter<=1 and kick_i=0, so expiry is tout_i*PRESC cycles after the last reload.
REQ-021 ARMED with gen_i=1 SHALL go to PULSE without setting expired_o; gen_i has priority over kick_i.
REQ-022 ARMED with mode_i=0 SHALL go to IDLE.
REQ-023 out_o SHALL be 1 in PULSE only, for exactly PULSE_LEN*PRESC cycles, starting at the edge that enters PULSE.
REQ-024 At end of pulse, the block SHALL go to HOLD if gen_i=1, else to ARMED with tout_i reloaded if mode_i=1, else to IDLE.
REQ-025 HOLD SHALL keep out_o=0 until gen_i=0, then take the same mode_i-based exit as REQ-024.
REQ-026 kick_i and clr_i SHALL have no effect on out_o during PULSE.
REQ-027 expired_o SHALL be cleared by clr_i; set SHALL win over simultaneous clr_i.
REQ-028 The pulse tick counter SHALL be ceil(log2(PULSE_LEN+1)) bits wide; the timeout counter SHALL never wrap below 0.

Reset
REQ-029 reset_i SHALL immediately force IDLE, out_o=0, busy_o=0, expired_o=0, and all counters and the prescaler to 0, including mid-pulse.
REQ-030 After reset_i is released, the block SHALL act on inputs from the first clock_i edge.

Verification (PRESC=1, PULSE_LEN=10, CNT_W=8)
REQ-031 mode_i=0, ena_i=1, gen_i high for 30 cycles -> out_o=1 for exactly 10 cycles starting 1 edge after gen_i is sampled; busy_o high until 1 cycle after gen_i falls; expired_o stays 0.
REQ-032 mode_i=1, tout_i=5, no kick -> out_o rises 5 cycles after ARMED entry and lasts 10 cycles; expired_o=1; the block re-arms and expires again 5 cycles after the pulse ends.
REQ-033 mode_i=1, tout_i=5, kick_i every 4 cycles for 100 cycles -> out_o stays 0 and expired_o stays 0.
REQ-034 ena_i dropped at cycle 4 of a pulse -> out_o=0 on the next edge, state IDLE, no HOLD.
REQ-035 reset_i asserted mid-pulse asynchronously -> out_o=0 and expired_o=0 immediately; tout_i=0 with no kick then expires 1 cycle after arming.
REQ-036 clr_i asserted on the expiry edge -> expired_o=1; clr_i one cycle later -> expired_o=0.
